// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM bus peripheral: register offsets, CTRL bit
// positions, read FSM states and the byte-strobe merge helper.
package pwm_pkg;

    localparam int unsigned OFF_CTRL     = 32'h00;
    localparam int unsigned OFF_PERIOD   = 32'h04;
    localparam int unsigned OFF_DUTY     = 32'h08;
    localparam int unsigned OFF_PRESCALE = 32'h0C;
    localparam int unsigned OFF_COUNT    = 32'h10;
    localparam int unsigned OFF_STATUS   = 32'h14;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int CTRL_CLR    = 2;
    localparam int CTRL_IRQ_EN = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// Simple single-beat register bus between a protocol bridge and a peripheral.
// Handshake: a request is a cycle with wen or ren high; error answers it in the
// same cycle; a read is accepted while request_stall=1 and the bridge holds
// ren/addr until request_stall drops, at which point rdata is valid.
interface bus_protocol_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wen;
    logic                    ren;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] strobe;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    request_stall;

    modport peripheral_vital (
        input  wen, ren, addr, wdata, strobe,
        output rdata, error, request_stall
    );

    modport bridge (
        output wen, ren, addr, wdata, strobe,
        input  rdata, error, request_stall
    );
endinterface

// File: rtl/pwm_bus_peripheral_core.sv
// PWM engine: prescaler, period counter, active (shadow-loaded) period/duty
// registers and the registered output comparator.
module pwm_core #(
    parameter int CNT_WIDTH = 16,
    parameter int PS_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 inv,
    input  logic [CNT_WIDTH-1:0] period_sh,
    input  logic [CNT_WIDTH-1:0] duty_sh,
    input  logic [PS_WIDTH-1:0]  prescale,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 wrap,
    output logic                 pwm_out
);

    logic [PS_WIDTH-1:0]  ps_q, ps_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
    logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
    logic                 pwm_q, pwm_d;

    always_comb begin
        ps_d         = ps_q;
        count_d      = count_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        wrap         = 1'b0;
        if (!en) begin
            ps_d         = '0;
            count_d      = '0;
            period_act_d = period_sh;
            duty_act_d   = duty_sh;
        end else if (clr) begin
            ps_d    = '0;
            count_d = '0;
        // >= keeps the prescaler from running the long way round if PRESCALE shrinks mid-count
        end else if (ps_q >= prescale) begin
            ps_d = '0;
            if (count_q == period_act_q) begin
                count_d      = '0;
                period_act_d = period_sh;
                duty_act_d   = duty_sh;
                wrap         = 1'b1;
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else begin
            ps_d = ps_q + PS_WIDTH'(1);
        end
        pwm_d = (en & (count_q < duty_act_q)) ^ inv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q         <= '0;
            count_q      <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            pwm_q        <= 1'b0;
        end else begin
            ps_q         <= ps_d;
            count_q      <= count_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pwm_q        <= pwm_d;
        end
    end

    assign count   = count_q;
    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_bus_peripheral.sv
// Memory-mapped PWM channel: address decode, error response, register file,
// one-wait-state read FSM and the level interrupt.
module pwm_bus_peripheral
    import pwm_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int PS_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    bus_protocol_if.peripheral_vital bp,
    output logic                     pwm_out,
    output logic                     irq,
    output logic                     dbg_rd_state
);

    logic [3:0]            ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  duty_q, duty_d;
    logic [PS_WIDTH-1:0]   prescale_q, prescale_d;
    logic                  wrap_q, wrap_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    rd_state_t             state_q, state_d;

    logic sel_ctrl, sel_period, sel_duty, sel_prescale, sel_count, sel_status;
    logic err, wr_ok, rd_ok, clr, stall;
    logic [31:0] rd_val;
    logic [CNT_WIDTH-1:0] count;
    logic wrap_pulse;

    always_comb begin
        sel_ctrl     = (bp.addr == ADDR_WIDTH'(OFF_CTRL));
        sel_period   = (bp.addr == ADDR_WIDTH'(OFF_PERIOD));
        sel_duty     = (bp.addr == ADDR_WIDTH'(OFF_DUTY));
        sel_prescale = (bp.addr == ADDR_WIDTH'(OFF_PRESCALE));
        sel_count    = (bp.addr == ADDR_WIDTH'(OFF_COUNT));
        sel_status   = (bp.addr == ADDR_WIDTH'(OFF_STATUS));
        err = (bp.wen | bp.ren) &
              ((bp.addr[1:0] != 2'b00) |
               !(sel_ctrl | sel_period | sel_duty | sel_prescale | sel_count | sel_status) |
               (bp.wen & sel_count) |
               (bp.wen & bp.ren));
        wr_ok = bp.wen & !err;
        rd_ok = bp.ren & !err;
    end

    // Register file writes; CLR is a write-only pulse and never stored.
    always_comb begin
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        duty_d     = duty_q;
        prescale_d = prescale_q;
        clr        = 1'b0;
        if (wr_ok && sel_ctrl) begin
            ctrl_d = 4'(apply_strobe(32'(ctrl_q), bp.wdata, bp.strobe)) & 4'b1011;
            clr    = bp.strobe[0] & bp.wdata[CTRL_CLR];
        end
        if (wr_ok && sel_period)
            period_d = CNT_WIDTH'(apply_strobe(32'(period_q), bp.wdata, bp.strobe));
        if (wr_ok && sel_duty)
            duty_d = CNT_WIDTH'(apply_strobe(32'(duty_q), bp.wdata, bp.strobe));
        if (wr_ok && sel_prescale)
            prescale_d = PS_WIDTH'(apply_strobe(32'(prescale_q), bp.wdata, bp.strobe));
        // A wrap in the same cycle as the W1C keeps the flag set.
        wrap_d = wrap_pulse |
                 (wrap_q & ~(wr_ok & sel_status & bp.strobe[0] & bp.wdata[0]));
    end

    always_comb begin
        rd_val = '0;
        if (sel_ctrl)     rd_val = 32'(ctrl_q);
        if (sel_period)   rd_val = 32'(period_q);
        if (sel_duty)     rd_val = 32'(duty_q);
        if (sel_prescale) rd_val = 32'(prescale_q);
        if (sel_count)    rd_val = 32'(count);
        if (sel_status)   rd_val = {31'b0, wrap_q};
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    stall   = 1'b1;
                    rdata_d = DATA_WIDTH'(rd_val);
                    state_d = RD_DATA;
                end
            end
            RD_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            prescale_q <= '0;
            wrap_q     <= 1'b0;
            rdata_q    <= '0;
            state_q    <= IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            prescale_q <= prescale_d;
            wrap_q     <= wrap_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
        end
    end

    pwm_core #(
        .CNT_WIDTH (CNT_WIDTH),
        .PS_WIDTH  (PS_WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (ctrl_q[CTRL_EN]),
        .clr       (clr),
        .inv       (ctrl_q[CTRL_INV]),
        .period_sh (period_q),
        .duty_sh   (duty_q),
        .prescale  (prescale_q),
        .count     (count),
        .wrap      (wrap_pulse),
        .pwm_out   (pwm_out)
    );

    assign bp.rdata         = rdata_q;
    assign bp.error         = err;
    assign bp.request_stall = stall & ~rst;
    assign irq              = wrap_q & ctrl_q[CTRL_IRQ_EN];
    assign dbg_rd_state     = (state_q == RD_DATA);

endmodule
